agc_loop_ctrl: RTL

- Closed-loop controller for the AGC datapath: the other end of the scale/offset load interface of the AGC DSP slice.
- Consumes the slice's per-sample `abs`/`gt`/`lt` outputs and accumulates statistics over a fixed window.
- Computes a new 17-bit scale and Q8.8 offset each window, then drives the two-stage load handshake:
  - stage-1 strobes `ce_scale`/`ce_offset`;
  - then a global `apply` that moves stage 1 into stage 2.
- One instance per channel; `apply_o` can be OR'd with other channels for simultaneous application.

---
 rtl/agc_pkg.sv | 33 +++
 rtl/agc_loop_ctrl_if.sv | 43 ++++
 rtl/agc_stat_accum.sv | 83 ++++++++
 rtl/agc_loop_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC loop controller and its statistics accumulator.
// Q-format anchors and the saturating helper used by the scale update.
package agc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        COMPUTE = 3'd2,
        LOAD    = 3'd3,
        APPLY   = 3'd4,
        SETTLE  = 3'd5
    } agc_state_e;

    localparam int Q_SCALE        = 12;
    localparam int Q_OFFSET       = 8;
    localparam int SCALE_W        = 17;
    localparam int SCALE_INIT_DEF = 1 << Q_SCALE;

    // Scale arithmetic runs one bit wider than the register so that +STEP can never wrap.
    function automatic logic [SCALE_W-1:0] clamp_scale(
        input logic [SCALE_W:0] value,
        input logic [SCALE_W:0] lo,
        input logic [SCALE_W:0] hi
    );
        if (value < lo) begin
            return SCALE_W'(lo);
        end else if (value > hi) begin
            return SCALE_W'(hi);
        end
        return SCALE_W'(value);
    endfunction

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// Sample stream from the AGC slice and the two-stage scale/offset load bus back into it.
// The controller takes the master side; the DSP slice (or a bench) takes the slave side.
interface agc_loop_ctrl_if #(
    parameter int NBITS       = 5,
    parameter int OFFSET_BITS = 16
);

    logic                   dat_valid_i;
    logic [NBITS-2:0]       abs_i;
    logic                   gt_i;
    logic                   lt_i;

    logic [16:0]            scale_o;
    logic [OFFSET_BITS-1:0] offset_o;
    logic                   ce_scale_o;
    logic                   ce_offset_o;
    logic                   apply_o;

    modport master (
        input  dat_valid_i,
        input  abs_i,
        input  gt_i,
        input  lt_i,
        output scale_o,
        output offset_o,
        output ce_scale_o,
        output ce_offset_o,
        output apply_o
    );

    modport slave (
        output dat_valid_i,
        output abs_i,
        output gt_i,
        output lt_i,
        input  scale_o,
        input  offset_o,
        input  ce_scale_o,
        input  ce_offset_o,
        input  apply_o
    );

endinterface

// File: rtl/agc_stat_accum.sv
// Window statistics: valid-sample counter, abs sum and gt/lt occurrence counters.
// done_o flags the sample that completes the window, in the same cycle it is presented.
module agc_stat_accum #(
    parameter int  NBITS       = 5,
    parameter int  WINDOW_LOG2 = 10,
    localparam int SW          = NBITS - 1 + WINDOW_LOG2,
    localparam int CW          = WINDOW_LOG2 + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [NBITS-2:0] abs_i,
    input  logic             gt_i,
    input  logic             lt_i,
    output logic [SW-1:0]    sum_o,
    output logic [CW-1:0]    gt_cnt_o,
    output logic [CW-1:0]    lt_cnt_o,
    output logic             done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;
    logic [1:0]    flag_in;
    logic [CW-1:0] flag_cnt [2];

    assign flag_in = {lt_i, gt_i};

    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clear_i) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
            sum_d = sum_q + SW'(abs_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    // gt and lt are counted independently, so a sample flagging both nets to zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
        logic [CW-1:0] fcnt_q;
        logic [CW-1:0] fcnt_d;

        always_comb begin
            fcnt_d = fcnt_q;
            if (clear_i) begin
                fcnt_d = '0;
            end else if (en_i && flag_in[gi]) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_d;
            end
        end

        assign flag_cnt[gi] = fcnt_q;
    end

    assign sum_o    = sum_q;
    assign gt_cnt_o = flag_cnt[0];
    assign lt_cnt_o = flag_cnt[1];
    assign done_o   = en_i && !clear_i && (cnt_q == CW'((1 << WINDOW_LOG2) - 1));

endmodule

// File: rtl/agc_loop_ctrl.sv
// Per-channel AGC loop: window statistics -> scale/offset update -> stage-1 load -> apply -> settle.
// Strobes are registered so reset removes them immediately and the post-reset init load is clean.
module agc_loop_ctrl
    import agc_pkg::*;
#(
    parameter int  NBITS         = 5,
    parameter int  OFFSET_BITS   = 16,
    parameter int  WINDOW_LOG2   = 10,
    parameter int  SCALE_INIT    = SCALE_INIT_DEF,
    parameter int  OFFSET_INIT   = 0,
    parameter int  SCALE_MIN     = 256,
    parameter int  SCALE_MAX     = 131071,
    parameter int  SCALE_STEP    = 16,
    parameter int  OFFSET_STEP   = 16,
    parameter int  TARGET_SUM    = 3277,
    parameter int  DEADBAND_SUM  = 128,
    parameter int  OFFSET_THRESH = 64,
    parameter int  HOLDOFF       = 8,
    localparam int SW            = NBITS - 1 + WINDOW_LOG2,
    localparam int IW            = WINDOW_LOG2 + 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    agc_loop_ctrl_if.master     bus,
    output logic                update_o,
    output logic [SW-1:0]       win_sum_o,
    output logic [IW-1:0]       win_imbal_o
);

    localparam int CW  = WINDOW_LOG2 + 1;
    localparam int OXW = OFFSET_BITS + 1;
    localparam int HCW = $clog2(HOLDOFF + 1);

    localparam logic [OFFSET_BITS-1:0] OFF_MAX = {1'b0, {(OFFSET_BITS-1){1'b1}}};
    localparam logic [OFFSET_BITS-1:0] OFF_MIN = {1'b1, {(OFFSET_BITS-1){1'b0}}};
    localparam logic signed [OXW-1:0]  OFF_MAX_X = $signed({1'b0, OFF_MAX});
    localparam logic signed [OXW-1:0]  OFF_MIN_X = $signed({1'b1, OFF_MIN});

    agc_state_e              state_q, state_d;
    logic                    init_q, init_d;
    logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [SCALE_W-1:0]      scale_q, scale_d;
    logic [OFFSET_BITS-1:0]  offset_q, offset_d;
    logic                    ce_q, ce_d;
    logic                    apply_q, apply_d;
    logic                    update_q, update_d;
    logic [SW-1:0]           win_sum_q, win_sum_d;
    logic [IW-1:0]           win_imbal_q, win_imbal_d;

    logic                    acc_en;
    logic                    acc_clear;
    logic                    acc_done;
    logic [SW-1:0]           acc_sum;
    logic [CW-1:0]           acc_gt;
    logic [CW-1:0]           acc_lt;

    logic signed [IW-1:0]    imbal;
    logic                    sum_hi, sum_lo, off_hi, off_lo;
    logic [SCALE_W:0]        scale_ext, scale_up, scale_dn;
    logic [SCALE_W-1:0]      scale_calc;
    logic signed [OXW-1:0]   off_ext, off_raw;
    logic [OFFSET_BITS-1:0]  offset_calc;

    // Accumulators only see samples inside an enabled window; every other state keeps them cleared.
    assign acc_en    = (state_q == ACCUM) && enable_i && bus.dat_valid_i;
    assign acc_clear = (state_q != ACCUM);

    agc_stat_accum #(
        .NBITS       (NBITS),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_stat (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (acc_clear),
        .en_i     (acc_en),
        .abs_i    (bus.abs_i),
        .gt_i     (bus.gt_i),
        .lt_i     (bus.lt_i),
        .sum_o    (acc_sum),
        .gt_cnt_o (acc_gt),
        .lt_cnt_o (acc_lt),
        .done_o   (acc_done)
    );

    assign imbal  = $signed({1'b0, acc_gt}) - $signed({1'b0, acc_lt});
    assign sum_hi = int'(acc_sum) > (TARGET_SUM + DEADBAND_SUM);
    assign sum_lo = int'(acc_sum) < (TARGET_SUM - DEADBAND_SUM);
    assign off_hi = int'(imbal) > OFFSET_THRESH;
    assign off_lo = int'(imbal) < -OFFSET_THRESH;

    // Too much energy lowers the gain; positive imbalance pulls the offset down.
    always_comb begin
        scale_ext = {1'b0, scale_q};
        scale_up  = scale_ext + (SCALE_W+1)'(SCALE_STEP);
        scale_dn  = (scale_ext < (SCALE_W+1)'(SCALE_STEP)) ? '0
                                                           : scale_ext - (SCALE_W+1)'(SCALE_STEP);
        if (sum_hi) begin
            scale_calc = clamp_scale(scale_dn, (SCALE_W+1)'(SCALE_MIN), (SCALE_W+1)'(SCALE_MAX));
        end else if (sum_lo) begin
            scale_calc = clamp_scale(scale_up, (SCALE_W+1)'(SCALE_MIN), (SCALE_W+1)'(SCALE_MAX));
        end else begin
            scale_calc = clamp_scale(scale_ext, (SCALE_W+1)'(SCALE_MIN), (SCALE_W+1)'(SCALE_MAX));
        end
    end

    always_comb begin
        off_ext = $signed({offset_q[OFFSET_BITS-1], offset_q});
        off_raw = off_ext;
        if (off_hi) begin
            off_raw = off_ext - $signed(OXW'(OFFSET_STEP));
        end else if (off_lo) begin
            off_raw = off_ext + $signed(OXW'(OFFSET_STEP));
        end
        if (off_raw > OFF_MAX_X) begin
            offset_calc = OFF_MAX;
        end else if (off_raw < OFF_MIN_X) begin
            offset_calc = OFF_MIN;
        end else begin
            offset_calc = off_raw[OFFSET_BITS-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        scale_d     = scale_q;
        offset_d    = offset_q;
        win_sum_d   = win_sum_q;
        win_imbal_d = win_imbal_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (acc_done) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                state_d     = LOAD;
                scale_d     = scale_calc;
                offset_d    = offset_calc;
                win_sum_d   = acc_sum;
                win_imbal_d = imbal;
            end
            LOAD: begin
                // Out of reset, hold LOAD one extra cycle so the init strobe is actually driven.
                state_d = init_q ? LOAD : APPLY;
            end
            APPLY: begin
                state_d    = SETTLE;
                hold_cnt_d = '0;
            end
            SETTLE: begin
                if (hold_cnt_q == HCW'(HOLDOFF - 1)) begin
                    state_d = enable_i ? ACCUM : IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ce_d     = (state_d == LOAD);
        apply_d  = (state_d == APPLY);
        update_d = (state_d == COMPUTE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOAD;
            init_q      <= 1'b1;
            hold_cnt_q  <= '0;
            scale_q     <= SCALE_W'(SCALE_INIT);
            offset_q    <= OFFSET_BITS'(OFFSET_INIT);
            ce_q        <= 1'b0;
            apply_q     <= 1'b0;
            update_q    <= 1'b0;
            win_sum_q   <= '0;
            win_imbal_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            hold_cnt_q  <= hold_cnt_d;
            scale_q     <= scale_d;
            offset_q    <= offset_d;
            ce_q        <= ce_d;
            apply_q     <= apply_d;
            update_q    <= update_d;
            win_sum_q   <= win_sum_d;
            win_imbal_q <= win_imbal_d;
        end
    end

    assign bus.scale_o     = scale_q;
    assign bus.offset_o    = offset_q;
    assign bus.ce_scale_o  = ce_q;
    assign bus.ce_offset_o = ce_q;
    assign bus.apply_o     = apply_q;
    assign update_o        = update_q;
    assign win_sum_o       = win_sum_q;
    assign win_imbal_o     = win_imbal_q;

endmodule
